// File: rtl/sc_game_defs_pkg.sv
// Shared game-flow definitions: state codes on the level-counter bus and
// bus widths. The state codes must match the level counter's decoder.
package sc_game_defs;

  localparam int STATE_W = 2;
  localparam int LEVEL_W = 3;

  localparam logic [STATE_W-1:0] AWAITSTART_0 = 2'd0;
  localparam logic [STATE_W-1:0] STARTGAME_0  = 2'd1;
  localparam logic [STATE_W-1:0] ENDGAME_0    = 2'd2;
  localparam logic [STATE_W-1:0] AWAITSTART_1 = 2'd3;

  // Counter value shown while the end-game screen is up.
  localparam logic [LEVEL_W-1:0] LEVEL_ENDGAME = 3'd7;

  // Level the counter will hold once any strobe already on the wire is
  // absorbed; one bit wider so level 7 plus a pending strobe cannot wrap.
  function automatic logic [LEVEL_W:0] eff_level(input logic [LEVEL_W-1:0] level,
                                                 input logic count_n);
    eff_level = {1'b0, level} + {{LEVEL_W{1'b0}}, ~count_n};
  endfunction

endpackage

// File: rtl/sc_button_sync.sv
// Start-button conditioning: two-flop synchronizer followed by a
// falling-edge detector that emits a single-cycle pulse per press.
module sc_button_sync (
  input  logic SC_LEVELCOUNTER_CLOCK_50,
  input  logic SC_LEVELCOUNTER_RESET_InHigh,
  input  logic i_button_n,
  output logic o_fall_pulse
);

  logic [1:0] r_sync;
  logic       r_prev;

  // Everything resets high so a released button never looks like a press.
  always_ff @(posedge SC_LEVELCOUNTER_CLOCK_50 or posedge SC_LEVELCOUNTER_RESET_InHigh) begin
    if (SC_LEVELCOUNTER_RESET_InHigh) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_button_n};
      r_prev <= r_sync[1];
    end
  end

  assign o_fall_pulse = r_prev & ~r_sync[1];

endmodule

// File: rtl/sc_gamestate_controller.sv
// Game-flow FSM: drives the level counter's state bus and level-up strobe,
// tracks lives, and decides win/loss from the counter's level feedback.
module sc_gamestate_controller
  import sc_game_defs::*;
#(
  parameter int LIVES_INIT   = 3,
  parameter int MAX_LEVEL    = 6,
  parameter int ENDGAME_HOLD = 100_000_000,
  parameter int HOLD_WIDTH   = 27
) (
  input  logic               SC_LEVELCOUNTER_CLOCK_50,
  input  logic               SC_LEVELCOUNTER_RESET_InHigh,
  input  logic               SC_GAMESTATE_Start_InLow,
  input  logic               SC_GAMESTATE_Goal_InHigh,
  input  logic               SC_GAMESTATE_Collision_InHigh,
  input  logic [LEVEL_W-1:0] SC_GAMESTATE_Level_InBus,
  output logic [STATE_W-1:0] SC_GAMESTATE_CurrentState_OutBus,
  output logic               SC_GAMESTATE_CountSignal_OutLow,
  output logic [1:0]         SC_GAMESTATE_Lives_OutBus,
  output logic               SC_GAMESTATE_Win_OutHigh
);

  localparam logic [1:0]            LIVES_LOAD = 2'(LIVES_INIT);
  localparam logic [LEVEL_W:0]      WIN_LEVEL  = (LEVEL_W+1)'(MAX_LEVEL);
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST  = HOLD_WIDTH'(ENDGAME_HOLD - 1);

  logic                  w_start_evt;
  logic [STATE_W-1:0]    r_state;
  logic [STATE_W-1:0]    w_state_next;
  logic [1:0]            r_lives;
  logic [1:0]            w_lives_next;
  logic                  r_win;
  logic                  w_win_next;
  logic                  r_count_n;
  logic                  w_count_n_next;
  logic [HOLD_WIDTH-1:0] r_hold;
  logic [HOLD_WIDTH-1:0] w_hold_next;
  logic [LEVEL_W:0]      w_eff_level;
  logic                  w_hold_done;

  sc_button_sync u_start_sync (
    .SC_LEVELCOUNTER_CLOCK_50     (SC_LEVELCOUNTER_CLOCK_50),
    .SC_LEVELCOUNTER_RESET_InHigh (SC_LEVELCOUNTER_RESET_InHigh),
    .i_button_n                   (SC_GAMESTATE_Start_InLow),
    .o_fall_pulse                 (w_start_evt)
  );

  assign w_eff_level = eff_level(SC_GAMESTATE_Level_InBus, r_count_n);
  assign w_hold_done = (r_hold == HOLD_LAST);

  always_comb begin
    w_state_next   = r_state;
    w_lives_next   = r_lives;
    w_win_next     = r_win;
    w_count_n_next = 1'b1;
    w_hold_next    = r_hold;

    case (r_state)
      AWAITSTART_0: begin
        if (w_start_evt) begin
          w_state_next = AWAITSTART_1;
        end
      end

      AWAITSTART_1: begin
        w_lives_next = LIVES_LOAD;
        w_win_next   = 1'b0;
        w_state_next = STARTGAME_0;
      end

      STARTGAME_0: begin
        // Collision wins over a simultaneous goal; that goal is dropped.
        if (SC_GAMESTATE_Collision_InHigh) begin
          if (r_lives == 2'd1) begin
            w_lives_next = 2'd0;
            w_win_next   = 1'b0;
            w_hold_next  = '0;
            w_state_next = ENDGAME_0;
          end else begin
            w_lives_next = r_lives - 2'd1;
          end
        end else if (SC_GAMESTATE_Goal_InHigh) begin
          if (w_eff_level >= WIN_LEVEL) begin
            w_win_next   = 1'b1;
            w_hold_next  = '0;
            w_state_next = ENDGAME_0;
          end else begin
            w_count_n_next = 1'b0;
          end
        end
      end

      ENDGAME_0: begin
        if (w_hold_done) begin
          w_win_next   = 1'b0;
          w_hold_next  = '0;
          w_state_next = AWAITSTART_0;
        end else begin
          w_hold_next = r_hold + 1'b1;
        end
      end

      default: begin
        w_state_next = AWAITSTART_0;
      end
    endcase
  end

  always_ff @(posedge SC_LEVELCOUNTER_CLOCK_50 or posedge SC_LEVELCOUNTER_RESET_InHigh) begin
    if (SC_LEVELCOUNTER_RESET_InHigh) begin
      r_state   <= AWAITSTART_0;
      r_lives   <= 2'd0;
      r_win     <= 1'b0;
      r_count_n <= 1'b1;
      r_hold    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_lives   <= w_lives_next;
      r_win     <= w_win_next;
      r_count_n <= w_count_n_next;
      r_hold    <= w_hold_next;
    end
  end

  assign SC_GAMESTATE_CurrentState_OutBus = r_state;
  assign SC_GAMESTATE_CountSignal_OutLow  = r_count_n;
  assign SC_GAMESTATE_Lives_OutBus        = r_lives;
  assign SC_GAMESTATE_Win_OutHigh         = r_win;

endmodule

// File: tb/tb_sc_gamestate_controller.sv
// Randomized bench for sc_gamestate_controller against a cycle-level game
// model built from the game rules (press history, lives count, endgame age).
module tb_sc_gamestate_controller;

  localparam int LIVES_INIT   = 3;
  localparam int MAX_LEVEL    = 6;
  localparam int ENDGAME_HOLD = 8;
  localparam int HOLD_WIDTH   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_n = 1'b1;
  logic       goal = 1'b0;
  logic       coll = 1'b0;
  logic [2:0] level = 3'd0;
  logic [1:0] st_out;
  logic       cnt_out;
  logic [1:0] lives_out;
  logic       win_out;

  sc_gamestate_controller #(
    .LIVES_INIT   (LIVES_INIT),
    .MAX_LEVEL    (MAX_LEVEL),
    .ENDGAME_HOLD (ENDGAME_HOLD),
    .HOLD_WIDTH   (HOLD_WIDTH)
  ) dut (
    .SC_LEVELCOUNTER_CLOCK_50         (clk),
    .SC_LEVELCOUNTER_RESET_InHigh     (rst),
    .SC_GAMESTATE_Start_InLow         (start_n),
    .SC_GAMESTATE_Goal_InHigh         (goal),
    .SC_GAMESTATE_Collision_InHigh    (coll),
    .SC_GAMESTATE_Level_InBus         (level),
    .SC_GAMESTATE_CurrentState_OutBus (st_out),
    .SC_GAMESTATE_CountSignal_OutLow  (cnt_out),
    .SC_GAMESTATE_Lives_OutBus        (lives_out),
    .SC_GAMESTATE_Win_OutHigh         (win_out)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Game model: phase uses the bus values the level counter decodes.
  int m_state, m_lives, m_win, m_strobe, m_end_age;
  bit m_hist[3];  // raw button samples, newest first

  task automatic model_reset();
    m_state = 0; m_lives = 0; m_win = 0; m_strobe = 1; m_end_age = 0;
    for (int i = 0; i < 3; i++) m_hist[i] = 1'b1;
  endtask

  task automatic model_edge(input bit raw, input bit g, input bit c, input int lvl);
    bit press;
    int n_state, n_lives, n_win, n_strobe, n_age, eff;
    // A press is seen three edges after the first high-to-low sample pair.
    press = m_hist[2] && !m_hist[1];
    m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = raw;
    n_state = m_state; n_lives = m_lives; n_win = m_win; n_strobe = 1; n_age = m_end_age;
    case (m_state)
      0: if (press) n_state = 3;
      3: begin n_lives = LIVES_INIT; n_win = 0; n_state = 1; end
      1: begin
        if (c) begin
          if (m_lives == 1) begin n_lives = 0; n_win = 0; n_state = 2; n_age = 0; end
          else n_lives = m_lives - 1;
        end else if (g) begin
          eff = lvl + ((m_strobe == 0) ? 1 : 0);
          if (eff >= MAX_LEVEL) begin n_win = 1; n_state = 2; n_age = 0; end
          else n_strobe = 0;
        end
      end
      default: begin
        if (m_end_age == ENDGAME_HOLD - 1) begin n_state = 0; n_win = 0; end
        else n_age = m_end_age + 1;
      end
    endcase
    m_state = n_state; m_lives = n_lives; m_win = n_win; m_strobe = n_strobe; m_end_age = n_age;
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "_state"}, 32'(st_out), 32'(m_state));
    chk({pfx, "_strobe"}, 32'(cnt_out), 32'(m_strobe));
    chk({pfx, "_lives"}, 32'(lives_out), 32'(m_lives));
    chk({pfx, "_win"}, 32'(win_out), 32'(m_win));
  endtask

  task automatic step(input bit raw, input bit g, input bit c, input logic [2:0] lvl);
    start_n = raw; goal = g; coll = c; level = lvl;
    @(posedge clk);
    model_edge(raw, g, c, int'(lvl));
    @(negedge clk);
    $display("t=%0t raw=%b goal=%b coll=%b lvl=%0d -> state=%0d strobe=%b lives=%0d win=%b",
             $time, raw, g, c, lvl, st_out, cnt_out, lives_out, win_out);
    check_outputs("step");
  endtask

  initial begin
    int press_left;
    int gap_left;
    bit got;

    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;

    // Start press held 10 cycles, then a goal at level 2, then two
    // back-to-back goals at level 5 (second one must win).
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 3'd1);
    step(1'b1, 1'b1, 1'b0, 3'd2);
    step(1'b1, 1'b0, 1'b0, 3'd3);
    step(1'b1, 1'b1, 1'b1, 3'd3);
    step(1'b1, 1'b1, 1'b0, 3'd5);
    step(1'b1, 1'b1, 1'b0, 3'd5);
    for (int i = 0; i < ENDGAME_HOLD + 2; i++) step(1'b1, 1'b0, 1'b0, 3'd0);

    // Random play with occasional presses of random length.
    press_left = 0;
    gap_left = 0;
    for (int i = 0; i < 600; i++) begin
      bit raw, g, c;
      if (press_left > 0) begin
        press_left--;
        raw = 1'b0;
        if (press_left == 0) gap_left = $urandom_range(1, 4);
      end else if (gap_left > 0) begin
        gap_left--;
        raw = 1'b1;
      end else if ($urandom_range(0, 99) < 6) begin
        press_left = $urandom_range(1, 12);
        raw = 1'b0;
        press_left--;
        if (press_left == 0) gap_left = $urandom_range(1, 4);
      end else begin
        raw = 1'b1;
      end
      g = ($urandom_range(0, 99) < 30);
      c = ($urandom_range(0, 99) < 8);
      step(raw, g, c, 3'($urandom_range(0, 6)));
    end

    // Mid-game reset while the strobe is low.
    for (int i = 0; i < ENDGAME_HOLD + 2; i++) step(1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 3'd0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b0, 1'b1, 1'b0, 3'd0);
      if (m_strobe == 0) got = 1'b1;
    end
    if (!got) chk("strobe_wait_timeout", 32'(m_strobe), 32'd0);
    start_n = 1'b1;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
